regfile_wr_arbiter: RTL and testbench

//  - Shares the register file's single write port among NREQ writeback sources (e.g. ALU, load unit, mult/div).
//  - Each source has a valid/ready handshake into a 1-entry holding register.
//  - A round-robin arbiter picks at most one held entry per cycle and drives a registered write to the regfile.
//  - Exports a per-register pending mask so issue logic can stall on RAW hazards against not-yet-written results.

---
 rtl/regfile_wr_if.sv | 30 +++
 rtl/regfile_wr_arbiter.sv | 145 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wr_if.sv
// Writeback request and regfile write bundle shared between writeback sources and the arbiter.
// The arbiter (regfile_wr_arbiter) takes the slave modport; the sources and the regfile see master.
interface regfile_wr_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 24
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_write_enable;
  logic [AW-1:0]      rf_write_addr;
  logic [DW-1:0]      rf_write_data;
  logic [2**AW-1:0]   pend_mask;
  logic [15:0]        stat_grants;
  logic [15:0]        stat_stalls;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, rf_write_enable, rf_write_addr, rf_write_data, pend_mask,
    input  stat_grants, stat_stalls
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, rf_write_enable, rf_write_addr, rf_write_data, pend_mask,
    output stat_grants, stat_stalls
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one regfile write port among NREQ writeback sources, each with a
// 1-entry holding slot. Define REGARB_STATS_EN to enable the grant/stall counters.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 24
) (
  input  logic         clk,
  input  logic         rst,
  regfile_wr_if.slave  bus
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NR = 2 ** AW;

  logic [NREQ-1:0] held_q, held_d;
  logic [AW-1:0]   addr_q [NREQ];
  logic [AW-1:0]   addr_d [NREQ];
  logic [DW-1:0]   data_q [NREQ];
  logic [DW-1:0]   data_d [NREQ];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] ready;
  logic [NREQ-1:0] accept;
  logic [NR-1:0]   pend;

  // ptr_q is the first slot to search, i.e. one past the last grant.
  always_comb begin : arb
    int unsigned idx;
    logic [PW-1:0] idx_w;
    idx     = 0;
    idx_w   = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx   = (32'(ptr_q) + k) % NREQ;
      idx_w = PW'(idx);
      if (!gnt_any && held_q[idx_w]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_w;
      end
    end
    gnt = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  end

  assign ready  = ~held_q | gnt;
  assign accept = bus.req_valid & ready;

  always_comb begin
    held_d = held_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
      if (accept[i]) begin
        held_d[i] = 1'b1;
        addr_d[i] = bus.req_addr[i*AW +: AW];
        data_d[i] = bus.req_data[i*DW +: DW];
      end else if (gnt[i]) begin
        held_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt_any) begin
      ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      // r0 writes consume a grant but never reach the regfile.
      we_d    = (addr_q[gnt_idx] != '0);
      waddr_d = addr_q[gnt_idx];
      wdata_d = data_q[gnt_idx];
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (held_q[i]) pend[addr_q[i]] = 1'b1;
    end
    if (we_q) pend[waddr_q] = 1'b1;
    pend[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q  <= '0;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      held_q  <= held_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      for (int unsigned i = 0; i < NREQ; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.req_ready       = ready;
  assign bus.rf_write_enable = we_q;
  assign bus.rf_write_addr   = waddr_q;
  assign bus.rf_write_data   = wdata_q;
  assign bus.pend_mask       = pend;

`ifdef REGARB_STATS_EN
  logic [15:0] grants_q, stalls_q;
  logic        stall;

  assign stall = |(bus.req_valid & ~ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (gnt_any && grants_q != 16'hFFFF) grants_q <= grants_q + 16'd1;
      if (stall && stalls_q != 16'hFFFF) stalls_q <= stalls_q + 16'd1;
    end
  end

  assign bus.stat_grants = grants_q;
  assign bus.stat_stalls = stalls_q;
`else
  assign bus.stat_grants = '0;
  assign bus.stat_stalls = '0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed scenarios plus randomized traffic against a
// slot-level reference model; a negedge monitor pops expected writes and checks outputs.
module tb_regfile_wr_arbiter;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 24;

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wr_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  // Reference model: one entry per slot, a search-start pointer, and the last write stage.
  bit  m_held [NREQ];
  int  m_addr [NREQ];
  int  m_data [NREQ];
  bit  m_acc  [NREQ];
  int  m_ptr = 0;
  bit  m_we = 1'b0;
  int  m_waddr = 0;
  int  m_grants = 0;
  int  m_stalls = 0;
  wr_t exp_q[$];

  logic [NREQ-1:0]    dv = '0;
  logic [NREQ*AW-1:0] da = '0;
  logic [NREQ*DW-1:0] dd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int s;
      s = (m_ptr + k) % NREQ;
      if (m_held[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r);
    int  g;
    bit  stall;
    bit  rdy;
    if (r) begin
      for (int i = 0; i < NREQ; i++) begin
        m_held[i] = 1'b0;
        m_acc[i]  = 1'b0;
      end
      m_ptr = 0; m_we = 1'b0; m_waddr = 0; m_grants = 0; m_stalls = 0;
      return;
    end
    g = pick();
    stall = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rdy = !m_held[i] || (g == i);
      m_acc[i] = dv[i] && rdy;
      if (dv[i] && !rdy) stall = 1'b1;
    end
    if (g >= 0) begin
      m_we    = (m_addr[g] != 0);
      m_waddr = m_addr[g];
      if (m_we) exp_q.push_back('{m_addr[g], m_data[g]});
      m_ptr = (g + 1) % NREQ;
      if (m_grants < 65535) m_grants++;
    end else begin
      m_we = 1'b0;
    end
    if (stall && m_stalls < 65535) m_stalls++;
    for (int i = 0; i < NREQ; i++) begin
      if (m_acc[i]) begin
        m_held[i] = 1'b1;
        m_addr[i] = int'(da[i*AW +: AW]);
        m_data[i] = int'(dd[i*DW +: DW]);
      end else if (g == i) begin
        m_held[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc(input bit r);
    @(negedge clk);
    rst = r;
    bus.req_valid = dv;
    bus.req_addr  = da;
    bus.req_data  = dd;
    @(posedge clk);
    model_step(r);
  endtask

  task automatic set_req(input int i, input bit v, input int a, input int d);
    dv[i] = v;
    da[i*AW +: AW] = AW'(a);
    dd[i*DW +: DW] = DW'(d);
  endtask

  task automatic idle(input int n);
    dv = '0;
    for (int k = 0; k < n; k++) cyc(1'b0);
  endtask

  // Monitor: compares every visible output to the model and pops the scoreboard on each write.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        int g;
        logic [NREQ-1:0] er;
        logic [2**AW-1:0] ep;
        wr_t w;
        g = pick();
        for (int i = 0; i < NREQ; i++) er[i] = !m_held[i] || (g == i);
        chk("req_ready", bus.req_ready, er);
        ep = '0;
        for (int i = 0; i < NREQ; i++) if (m_held[i]) ep[m_addr[i]] = 1'b1;
        if (m_we) ep[m_waddr] = 1'b1;
        ep[0] = 1'b0;
        chk("pend_mask", bus.pend_mask, ep);
`ifdef REGARB_STATS_EN
        chk("stat_grants", bus.stat_grants, m_grants);
        chk("stat_stalls", bus.stat_stalls, m_stalls);
`else
        chk("stat_grants", bus.stat_grants, 0);
        chk("stat_stalls", bus.stat_stalls, 0);
`endif
        chk("rf_write_enable", bus.rf_write_enable, m_we);
        if (bus.rf_write_enable === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            w = exp_q.pop_front();
            chk("rf_write_addr", bus.rf_write_addr, w.a);
            chk("rf_write_data", bus.rf_write_data, w.d);
          end
        end
      end
    end
  end

  initial begin
    int cnt [NREQ];
    int bound;

    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // Reset held with every requester valid.
    dv = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i + 4, 24'h111111 * (i + 1));
    cyc(1'b1);
    mon_en = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    #1;
    chk("reset_we", bus.rf_write_enable, 0);
    chk("reset_pend", bus.pend_mask, 0);
    chk("reset_grants", bus.stat_grants, 0);
    chk("reset_stalls", bus.stat_stalls, 0);
    dv = '0;
    cyc(1'b0);

    // Single write.
    set_req(0, 1'b1, 5, 24'hABCDEF);
    cyc(1'b0);
    #1 chk("single_pend_E", bus.pend_mask[5], 1);
    dv = '0;
    cyc(1'b0);
    #1;
    chk("single_we", bus.rf_write_enable, 1);
    chk("single_addr", bus.rf_write_addr, 5);
    chk("single_data", bus.rf_write_data, 24'hABCDEF);
    chk("single_pend_E1", bus.pend_mask[5], 1);
    cyc(1'b0);
    #1 chk("single_pend_E2", bus.pend_mask[5], 0);
    idle(2);

    // Two streaming requesters, four writes each.
    cnt[0] = 0; cnt[1] = 0;
    bound = 0;
    while ((cnt[0] < 4 || cnt[1] < 4) && bound < 40) begin
      for (int i = 0; i < 2; i++) set_req(i, cnt[i] < 4, 10 + i * 8 + cnt[i], 24'h100 * (i + 1) + cnt[i]);
      cyc(1'b0);
      for (int i = 0; i < 2; i++) if (m_acc[i]) cnt[i]++;
      bound++;
    end
    chk("stream_done_in_bound", bound < 40, 1);
    idle(4);

    // r0 write consumes a grant without a regfile write.
    set_req(1, 1'b1, 0, 24'h123456);
    cyc(1'b0);
    #1 chk("r0_accepted", m_acc[1], 1);
    idle(3);

    // Collision on r7 right after reset so the search starts at slot 0.
    dv = '0;
    cyc(1'b1);
    set_req(0, 1'b1, 7, 24'h000001);
    set_req(1, 1'b1, 7, 24'h000002);
    cyc(1'b0);
    dv = '0;
    cyc(1'b0);
    #1 chk("coll_first", bus.rf_write_data, 24'h000001);
    cyc(1'b0);
    #1;
    chk("coll_second", bus.rf_write_data, 24'h000002);
    chk("coll_pend_held", bus.pend_mask[7], 1);
    cyc(1'b0);
    #1 chk("coll_pend_clear", bus.pend_mask[7], 0);
    idle(1);

    // Reset while slot 1 holds a write to r9.
    set_req(1, 1'b1, 9, 24'h090909);
    cyc(1'b0);
    dv = '0;
    cyc(1'b1);
    #1;
    chk("midrst_we", bus.rf_write_enable, 0);
    chk("midrst_pend", bus.pend_mask, 0);
    cyc(1'b0);
    #1 chk("midrst_we_after", bus.rf_write_enable, 0);
    set_req(0, 1'b1, 3, 24'h030303);
    cyc(1'b0);
    dv = '0;
    cyc(1'b0);
    #1 chk("midrst_next_write", bus.rf_write_addr, 3);
    idle(2);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), int'($urandom));
      cyc($urandom_range(0, 99) == 0);
    end
    idle(5);

    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
